// File: rtl/req_arbiter_rr4.sv
// 4-way request arbiter with registered one-hot grant, round-robin or fixed priority,
// per-owner hold limit and a mandatory idle cycle between consecutive grants.
module req_arbiter_rr4 #(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_HOLD   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic       HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_MAX     = 8'(MAX_HOLD);

    state_t     state_r, state_s;
    logic [1:0] ptr_r, ptr_s;
    logic [7:0] hold_cnt_r, hold_cnt_s;
    logic [3:0] gnt_r, gnt_s;
    logic [1:0] gnt_id_r, gnt_id_s;
    logic       gnt_valid_r;
    logic       preempt_r, preempt_s;
    logic [3:0] rot_s;
    logic [1:0] rr_off_s;
    logic [1:0] fp_win_s;
    logic [1:0] win_s;

    function automatic logic [3:0] id_to_onehot(input logic [1:0] id);
        logic [3:0] oh;
        case (id)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Winner selection: rotate req so bit 0 is the pointer position, pick the lowest set bit.
    always_comb begin
        rot_s    = 4'b0000;
        rr_off_s = 2'd0;
        fp_win_s = 2'd0;
        case (ptr_r)
            2'd0:    rot_s = req;
            2'd1:    rot_s = {req[0], req[3:1]};
            2'd2:    rot_s = {req[1:0], req[3:2]};
            2'd3:    rot_s = {req[2:0], req[3]};
            default: rot_s = req;
        endcase
        casez (rot_s)
            4'b???1: rr_off_s = 2'd0;
            4'b??10: rr_off_s = 2'd1;
            4'b?100: rr_off_s = 2'd2;
            4'b1000: rr_off_s = 2'd3;
            default: rr_off_s = 2'd0;
        endcase
        casez (req)
            4'b1???: fp_win_s = 2'd3;
            4'b01??: fp_win_s = 2'd2;
            4'b001?: fp_win_s = 2'd1;
            4'b0001: fp_win_s = 2'd0;
            default: fp_win_s = 2'd0;
        endcase
        if (FIXED_PRIO != 0) begin
            win_s = fp_win_s;
        end else begin
            win_s = ptr_r + rr_off_s;
        end
    end

    // Next-state and next-output logic for the IDLE/BUSY grant FSM.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        gnt_s      = gnt_r;
        gnt_id_s   = gnt_id_r;
        preempt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 4'b0000) begin
                    gnt_s      = id_to_onehot(win_s);
                    gnt_id_s   = win_s;
                    ptr_s      = win_s + 2'd1;
                    hold_cnt_s = 8'd1;
                    state_s    = BUSY;
                end else begin
                    gnt_s    = 4'b0000;
                    gnt_id_s = 2'd0;
                end
            end
            BUSY: begin
                // Release is checked first so it wins over a simultaneous timeout.
                if (!req[gnt_id_r]) begin
                    gnt_s    = 4'b0000;
                    gnt_id_s = 2'd0;
                    state_s  = IDLE;
                end else if (HOLD_LIMITED && (hold_cnt_r == HOLD_MAX)) begin
                    gnt_s     = 4'b0000;
                    gnt_id_s  = 2'd0;
                    preempt_s = 1'b1;
                    state_s   = IDLE;
                end else if (hold_cnt_r != 8'd255) begin
                    hold_cnt_s = hold_cnt_r + 8'd1;
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            default: begin
                state_s  = IDLE;
                gnt_s    = 4'b0000;
                gnt_id_s = 2'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= 2'd0;
            hold_cnt_r  <= 8'd0;
            gnt_r       <= 4'b0000;
            gnt_id_r    <= 2'd0;
            gnt_valid_r <= 1'b0;
            preempt_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            hold_cnt_r  <= hold_cnt_s;
            gnt_r       <= gnt_s;
            gnt_id_r    <= gnt_id_s;
            gnt_valid_r <= |gnt_s;
            preempt_r   <= preempt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;
    assign preempt   = preempt_r;

endmodule

// File: tb/tb_req_arbiter_rr4.sv
// Directed bench for req_arbiter_rr4: one round-robin and one fixed-priority instance,
// observed as {gnt, gnt_id, gnt_valid, preempt}.
module tb_req_arbiter_rr4;

    logic       clk;
    logic       rst;
    logic [3:0] req_rr, req_fp;
    logic [3:0] gnt_rr, gnt_fp;
    logic [1:0] gnt_id_rr, gnt_id_fp;
    logic       gnt_valid_rr, gnt_valid_fp;
    logic       preempt_rr, preempt_fp;
    logic [7:0] obs_rr, obs_fp;
    int         n_cmp;
    int         n_bad;

    req_arbiter_rr4 #(.FIXED_PRIO(0), .MAX_HOLD(8)) u_rr (
        .clk(clk), .rst(rst), .req(req_rr), .gnt(gnt_rr), .gnt_id(gnt_id_rr),
        .gnt_valid(gnt_valid_rr), .preempt(preempt_rr)
    );

    req_arbiter_rr4 #(.FIXED_PRIO(1), .MAX_HOLD(8)) u_fp (
        .clk(clk), .rst(rst), .req(req_fp), .gnt(gnt_fp), .gnt_id(gnt_id_fp),
        .gnt_valid(gnt_valid_fp), .preempt(preempt_fp)
    );

    assign obs_rr = {gnt_rr, gnt_id_rr, gnt_valid_rr, preempt_rr};
    assign obs_fp = {gnt_fp, gnt_id_fp, gnt_valid_fp, preempt_fp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_rr = 4'b0000;
        req_fp = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req_rr = 4'b1111;
        req_fp = 4'b1111;
        step();
        step();
        n_cmp++;
        if (obs_rr !== 8'b0000_00_0_0) begin
            n_bad++;
            $display("FAIL reset_rr: got %b want %b", obs_rr, 8'b0000_00_0_0);
        end
        n_cmp++;
        if (obs_fp !== 8'b0000_00_0_0) begin
            n_bad++;
            $display("FAIL reset_fp: got %b want %b", obs_fp, 8'b0000_00_0_0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_rr();
        do_reset();
        req_rr = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs_rr !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL single_grant[%0d]: got %b want %b", i, obs_rr, {4'b0001, 2'd0, 1'b1, 1'b0});
            end
        end
        req_rr = 4'b0000;
        step();
        n_cmp++;
        if (obs_rr !== 8'b0000_00_0_0) begin
            n_bad++;
            $display("FAIL single_release: got %b want %b", obs_rr, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_round_robin();
        int         order[5];
        logic [3:0] oh;
        logic [7:0] exp_v;
        order = '{0, 1, 2, 3, 0};
        do_reset();
        req_rr = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            oh    = 4'b0001 << order[i];
            exp_v = {oh, 2'(order[i]), 1'b1, 1'b0};
            for (int c = 0; c < 2; c++) begin
                step();
                n_cmp++;
                if (obs_rr !== exp_v) begin
                    n_bad++;
                    $display("FAIL rr_grant[%0d] cyc %0d: got %b want %b", i, c, obs_rr, exp_v);
                end
            end
            req_rr = 4'b1111 & ~oh;
            step();
            n_cmp++;
            if (obs_rr !== 8'b0000_00_0_0) begin
                n_bad++;
                $display("FAIL rr_idle[%0d]: got %b want %b", i, obs_rr, 8'b0000_00_0_0);
            end
            req_rr = 4'b1111;
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        req_fp = 4'b0110;
        step();
        n_cmp++;
        if (obs_fp !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL fp_high: got %b want %b", obs_fp, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
        req_fp = 4'b0010;
        step();
        n_cmp++;
        if (obs_fp !== 8'b0000_00_0_0) begin
            n_bad++;
            $display("FAIL fp_release: got %b want %b", obs_fp, 8'b0000_00_0_0);
        end
        step();
        n_cmp++;
        if (obs_fp !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL fp_next: got %b want %b", obs_fp, {4'b0010, 2'd1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_timeout_rr();
        do_reset();
        req_rr = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (obs_rr !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL to_hold[%0d]: got %b want %b", i, obs_rr, {4'b0010, 2'd1, 1'b1, 1'b0});
            end
        end
        step();
        n_cmp++;
        if (obs_rr !== {4'b0000, 2'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL to_preempt: got %b want %b", obs_rr, {4'b0000, 2'd0, 1'b0, 1'b1});
        end
        step();
        n_cmp++;
        if (obs_rr !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL to_next: got %b want %b", obs_rr, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
    endtask

    task automatic test_timeout_fp();
        do_reset();
        req_fp = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            step();
        end
        n_cmp++;
        if (obs_fp !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL fp_to_hold8: got %b want %b", obs_fp, {4'b1000, 2'd3, 1'b1, 1'b0});
        end
        step();
        n_cmp++;
        if (obs_fp !== {4'b0000, 2'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL fp_to_preempt: got %b want %b", obs_fp, {4'b0000, 2'd0, 1'b0, 1'b1});
        end
        step();
        n_cmp++;
        if (obs_fp !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL fp_to_regrant: got %b want %b", obs_fp, {4'b1000, 2'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_release_vs_timeout();
        do_reset();
        req_rr = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
        end
        n_cmp++;
        if (obs_rr !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rvt_hold8: got %b want %b", obs_rr, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
        req_rr = 4'b0000;
        step();
        n_cmp++;
        if (obs_rr !== 8'b0000_00_0_0) begin
            n_bad++;
            $display("FAIL rvt_release: got %b want %b", obs_rr, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req_rr = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        n_cmp++;
        if (obs_rr !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_grant: got %b want %b", obs_rr, {4'b1000, 2'd3, 1'b1, 1'b0});
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (obs_rr !== 8'b0000_00_0_0) begin
            n_bad++;
            $display("FAIL mid_reset: got %b want %b", obs_rr, 8'b0000_00_0_0);
        end
        rst    = 1'b0;
        req_rr = 4'b1001;
        step();
        n_cmp++;
        if (obs_rr !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL ptr_after_reset: got %b want %b", obs_rr, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        req_rr = 4'b0000;
        req_fp = 4'b0000;
        test_reset();
        test_single_rr();
        test_round_robin();
        test_fixed_prio();
        test_timeout_rr();
        test_timeout_fp();
        test_release_vs_timeout();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
